// File: rtl/mux_pkg.sv
// Shared MUX serial definitions: receiver state encodings, baud divider table and
// the power-on line configuration used by the receiver, transmitter and CPU decode.
package mux_pkg;

  localparam int unsigned CLK_HZ = 27_000_000;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Power-on line setting: 9600 baud, 7 data bits, even parity, 1 stop bit
  localparam logic [15:0] DEF_DIVIDER     = 16'd2812;
  localparam logic [3:0]  DEF_DATA_BITS   = 4'd7;
  localparam logic        DEF_PARITY_EN   = 1'b1;
  localparam logic        DEF_PARITY_EVEN = 1'b1;
  localparam logic        DEF_STOP_BITS   = 1'b0;

  // 75 and 300 baud exceed the 16-bit divider; callers must range-check the result
  function automatic logic [31:0] baud_divider(input logic [2:0] sel);
    case (sel)
      3'd0:    return CLK_HZ / 75;
      3'd1:    return CLK_HZ / 300;
      3'd2:    return CLK_HZ / 1200;
      3'd3:    return CLK_HZ / 2400;
      3'd4:    return CLK_HZ / 4800;
      3'd5:    return CLK_HZ / 9600;
      3'd6:    return CLK_HZ / 19200;
      default: return CLK_HZ / 38400;
    endcase
  endfunction

  function automatic logic [3:0] norm_data_bits(input logic [3:0] n);
    return (n >= 4'd5 && n <= 4'd8) ? n : 4'd8;
  endfunction

endpackage

// File: rtl/mux_sync.sv
// Two-flop synchroniser for the async serial line; resets to the idle-high level.
module mux_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mux_uart_rx.sv
// Async serial receiver for one MUX channel: frames 5-8 data bits with optional
// parity, and holds each byte plus its error flags until the CPU acknowledges it.
module mux_uart_rx
  import mux_pkg::*;
#(
  parameter int unsigned MIN_DIVIDER = 4
) (
  input  logic        bit_clock,
  input  logic        reset,
  input  logic        uart_rx,
  input  logic [15:0] divider,
  input  logic [3:0]  data_bits,
  input  logic        parity_enabled,
  input  logic        parity,
  input  logic        stop_bits,
  input  logic        rx_ack,
  output logic [7:0]  rx_data,
  output logic        byte_ready,
  output logic        parity_error,
  output logic        framing_error,
  output logic        overrun_error,
  output logic        break_detect,
  output logic        rx_busy
);

  rx_state_t   state_q, state_d;
  logic        rx_s;
  logic [15:0] div_q, cnt_q;
  logic [3:0]  nbits_q, bit_idx_q;
  logic        par_en_q, par_even_q;
  logic [7:0]  shreg_q;
  logic        par_err_q, stop_low_q, deliver_q;
  logic        start_ok, mid_start, mid_bit, last_bit;

  // Only the first stop bit is checked, so the stop-bit count never reaches the logic
  logic unused_stop_bits;
  assign unused_stop_bits = stop_bits;

  mux_sync u_sync (
    .clk   (bit_clock),
    .reset (reset),
    .d     (uart_rx),
    .q     (rx_s)
  );

  assign start_ok  = !rx_s && (divider >= 16'(MIN_DIVIDER));
  assign mid_start = cnt_q == ({1'b0, div_q[15:1]} - 16'd1);
  assign mid_bit   = cnt_q == (div_q - 16'd1);
  assign last_bit  = bit_idx_q == (nbits_q - 4'd1);
  assign rx_busy   = state_q != RX_IDLE;

  always_ff @(posedge bit_clock) begin
    if (reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:      if (start_ok) state_d = RX_START;
      RX_START:     if (mid_start) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (mid_bit && last_bit) state_d = par_en_q ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (mid_bit) state_d = RX_STOP;
      RX_STOP:      if (mid_bit) state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) state_d = RX_IDLE;
      default:      state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge bit_clock) begin
    if (reset) begin
      cnt_q      <= '0;
      div_q      <= '0;
      nbits_q    <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      shreg_q    <= '0;
      par_err_q  <= 1'b0;
      stop_low_q <= 1'b0;
      deliver_q  <= 1'b0;
    end else begin
      deliver_q <= (state_q == RX_STOP) && mid_bit;
      case (state_q)
        RX_IDLE: begin
          if (start_ok) begin
            cnt_q      <= '0;
            div_q      <= divider;
            nbits_q    <= norm_data_bits(data_bits);
            par_en_q   <= parity_enabled;
            par_even_q <= parity;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            par_err_q  <= 1'b0;
          end
        end
        RX_START: cnt_q <= mid_start ? 16'd0 : cnt_q + 16'd1;
        RX_DATA: begin
          if (mid_bit) begin
            cnt_q                   <= '0;
            shreg_q[bit_idx_q[2:0]] <= rx_s;
            bit_idx_q               <= bit_idx_q + 4'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_PARITY: begin
          if (mid_bit) begin
            cnt_q     <= '0;
            par_err_q <= ((^shreg_q) ^ rx_s) != !par_even_q;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (mid_bit) begin
            cnt_q      <= '0;
            stop_low_q <= !rx_s;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // A delivery always wins over an ack; an ack in the same cycle only suppresses overrun
  always_ff @(posedge bit_clock) begin
    if (reset) begin
      rx_data       <= '0;
      byte_ready    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      break_detect  <= 1'b0;
    end else if (deliver_q) begin
      rx_data       <= shreg_q;
      parity_error  <= par_err_q;
      framing_error <= stop_low_q;
      break_detect  <= stop_low_q && (shreg_q == 8'd0);
      overrun_error <= byte_ready && !rx_ack;
      byte_ready    <= 1'b1;
    end else if (rx_ack && byte_ready) begin
      byte_ready    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      break_detect  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_uart_rx.sv
// Directed bench for mux_uart_rx: serial frames are driven on uart_rx, the expected
// held byte and flags are queued per frame and compared once the frame has completed.
module tb_mux_uart_rx;
  import mux_pkg::*;

  logic        bit_clock = 1'b0;
  logic        reset, uart_rx, rx_ack;
  logic [15:0] divider;
  logic [3:0]  data_bits;
  logic        parity_enabled, parity, stop_bits;
  logic [7:0]  rx_data;
  logic        byte_ready, parity_error, framing_error, overrun_error, break_detect, rx_busy;

  typedef struct {
    logic [7:0] d;
    logic       pe, fe, bd, ov;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 bit_clock = ~bit_clock;

  mux_uart_rx dut (
    .bit_clock      (bit_clock),
    .reset          (reset),
    .uart_rx        (uart_rx),
    .divider        (divider),
    .data_bits      (data_bits),
    .parity_enabled (parity_enabled),
    .parity         (parity),
    .stop_bits      (stop_bits),
    .rx_ack         (rx_ack),
    .rx_data        (rx_data),
    .byte_ready     (byte_ready),
    .parity_error   (parity_error),
    .framing_error  (framing_error),
    .overrun_error  (overrun_error),
    .break_detect   (break_detect),
    .rx_busy        (rx_busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge bit_clock);
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    uart_rx = b;
    repeat (cycles) @(negedge bit_clock);
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [3:0] nb, input logic pen,
                         input logic peven);
    divider        = div;
    data_bits      = nb;
    parity_enabled = pen;
    parity         = peven;
    stop_bits      = 1'b0;
  endtask

  // Drives one frame; corrupt inverts the correct parity bit. With ack_mode, rx_ack is
  // pulsed for the cycle in which the byte is delivered (first cycle after rx_busy drops).
  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic peven, input logic corrupt, input logic exp_ov,
                            input logic ack_mode, input int div);
    logic [7:0] dm;
    logic [7:0] mask;
    logic       pbit;
    logic       acked;
    exp_t       e;
    mask = 8'((1 << nb) - 1);
    dm   = d & mask;
    drive_bit(1'b0, div);
    for (int i = 0; i < nb; i++) drive_bit(dm[i], div);
    if (pen) begin
      pbit = peven ? ^dm : ~^dm;
      if (corrupt) pbit = ~pbit;
      drive_bit(pbit, div);
    end
    e.d = dm; e.pe = pen && corrupt; e.fe = 1'b0; e.bd = 1'b0; e.ov = exp_ov;
    sb.push_back(e);
    uart_rx = 1'b1;
    acked   = 1'b0;
    for (int i = 0; i < 2 * div; i++) begin
      @(negedge bit_clock);
      rx_ack = 1'b0;
      if (ack_mode && !acked && !rx_busy) begin
        rx_ack = 1'b1;
        acked  = 1'b1;
      end
    end
    rx_ack = 1'b0;
    if (ack_mode) chk("ack_on_delivery_window", 16'(acked), 16'd1);
  endtask

  task automatic check_held(input string tag);
    exp_t e;
    chk({tag, " pending"}, 16'(sb.size()), 16'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " byte_ready"},    16'(byte_ready),    16'd1);
      chk({tag, " rx_data"},       16'(rx_data),       16'(e.d));
      chk({tag, " parity_error"},  16'(parity_error),  16'(e.pe));
      chk({tag, " framing_error"}, 16'(framing_error), 16'(e.fe));
      chk({tag, " break_detect"},  16'(break_detect),  16'(e.bd));
      chk({tag, " overrun_error"}, 16'(overrun_error), 16'(e.ov));
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge bit_clock);
    rx_ack = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " rx_data"},       16'(rx_data),       16'd0);
    chk({tag, " byte_ready"},    16'(byte_ready),    16'd0);
    chk({tag, " parity_error"},  16'(parity_error),  16'd0);
    chk({tag, " framing_error"}, 16'(framing_error), 16'd0);
    chk({tag, " overrun_error"}, 16'(overrun_error), 16'd0);
    chk({tag, " break_detect"},  16'(break_detect),  16'd0);
    chk({tag, " rx_busy"},       16'(rx_busy),       16'd0);
  endtask

  initial begin
    logic [7:0] partial;
    reset   = 1'b1;
    uart_rx = 1'b1;
    rx_ack  = 1'b0;
    set_cfg(DEF_DIVIDER, DEF_DATA_BITS, DEF_PARITY_EN, DEF_PARITY_EVEN);
    idle(4);
    check_cleared("reset");
    reset = 1'b0;
    idle(4);

    // 1: 9600 7E1, 0x41
    set_cfg(16'd2812, 4'd7, 1'b1, 1'b1);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2812);
    check_held("t1");
    pulse_ack();
    chk("t1 ack byte_ready", 16'(byte_ready), 16'd0);

    // 2: 8O1 with an even parity bit
    set_cfg(16'd64, 4'd8, 1'b1, 1'b0);
    send_frame(8'h55, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64);
    check_held("t2");
    pulse_ack();
    chk("t2 ack parity_error", 16'(parity_error), 16'd0);

    // 3: start-bit glitch shorter than half a bit
    set_cfg(16'd2812, 4'd8, 1'b0, 1'b0);
    drive_bit(1'b0, 1000);
    drive_bit(1'b1, 2000);
    chk("t3 glitch rx_busy",    16'(rx_busy),    16'd0);
    chk("t3 glitch byte_ready", 16'(byte_ready), 16'd0);
    set_cfg(16'd64, 4'd8, 1'b0, 1'b0);
    send_frame(8'h30, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
    check_held("t3");
    pulse_ack();

    // 4: break, line low for three frame times
    set_cfg(16'd64, 4'd7, 1'b1, 1'b1);
    drive_bit(1'b0, 3 * 10 * 64);
    sb.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, bd: 1'b1, ov: 1'b0});
    check_held("t4");
    chk("t4 wait_high rx_busy", 16'(rx_busy), 16'd1);
    pulse_ack();
    idle(640);
    chk("t4 no retrigger byte_ready", 16'(byte_ready), 16'd0);
    chk("t4 still waiting rx_busy",   16'(rx_busy),    16'd1);
    drive_bit(1'b1, 8);
    chk("t4 released rx_busy",    16'(rx_busy),    16'd0);
    chk("t4 released byte_ready", 16'(byte_ready), 16'd0);

    // 5: overrun, then ack coincident with delivery
    set_cfg(16'd64, 4'd8, 1'b0, 1'b0);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
    check_held("t5a first");
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64);
    check_held("t5a overrun");
    pulse_ack();
    chk("t5 ack overrun_error", 16'(overrun_error), 16'd0);
    chk("t5 ack byte_ready",    16'(byte_ready),    16'd0);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
    check_held("t5b first");
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64);
    check_held("t5b ack_on_delivery");

    // 6: reset in the middle of data bit 3, 0x22 still held
    partial = 8'h5A;
    drive_bit(1'b0, 64);
    for (int i = 0; i < 3; i++) drive_bit(partial[i], 64);
    drive_bit(partial[3], 32);
    chk("t6 mid-frame rx_busy", 16'(rx_busy), 16'd1);
    reset   = 1'b1;
    uart_rx = 1'b1;
    idle(3);
    check_cleared("t6 reset");
    reset = 1'b0;
    idle(10);
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64);
    check_held("t6");
    chk("scoreboard drained", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
